instr_fetch_unit: RTL

//  Instruction store and fetch stage directly downstream of the program counter.

---
 rtl/instr_fetch_if.sv | 27 ++
 rtl/instr_fetch_unit.sv | 100 ++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus that joins the program counter and boot loader to the instruction store.
// The master side is the core and loader. The slave side is the fetch unit.
interface instr_fetch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] PC;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_done;
  logic              load_ready;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic              cpu_stall;
  logic              addr_err;
  logic [15:0]       fetch_count;

  modport master (
    output PC, load_valid, load_data, load_done,
    input  load_ready, instruction, instr_valid, cpu_stall, addr_err, fetch_count
  );

  modport slave (
    input  PC, load_valid, load_data, load_done,
    output load_ready, instruction, instr_valid, cpu_stall, addr_err, fetch_count
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction store with a boot-load FSM (LOAD -> RUN -> HALT) and a zero-latency fetch path.
// The core is stalled while loading, on a HALT word, on an out-of-range PC, and in HALT.
module instr_fetch_unit #(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 8,
  parameter int                 DEPTH     = 256,
  parameter logic [DATA_W-1:0]  HALT_WORD = {DATA_W{1'b1}}
) (
  input  logic          clk,
  input  logic          reset_n,
  instr_fetch_if.slave  bus
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W:0]   r_load_ptr;
  logic              r_addr_err;
  logic [15:0]       r_fetch_count;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_load_ready;
  logic              w_load_fire;
  logic              w_pc_in_range;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_is_halt;
  logic              w_issue;

  // load_ptr carries one extra bit so "store full" is representable without wrapping.
  assign w_load_ready  = (r_state == S_LOAD) && (r_load_ptr < DEPTH_C);
  assign w_load_fire   = w_load_ready && bus.load_valid;
  assign w_pc_in_range = ({1'b0, bus.PC} < DEPTH_C);
  assign w_rd_idx      = bus.PC[IDX_W-1:0];
  assign w_wr_idx      = r_load_ptr[IDX_W-1:0];
  assign w_rd_word     = r_mem[w_rd_idx];
  assign w_is_halt     = w_pc_in_range && (w_rd_word == HALT_WORD);
  assign w_issue       = (r_state == S_RUN) && w_pc_in_range && !w_is_halt;

  // Storage is deliberately not reset, so contents survive a reset until reloaded.
  always_ff @(posedge clk) begin
    if (reset_n && w_load_fire) begin
      r_mem[w_wr_idx] <= bus.load_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_LOAD;
      r_load_ptr    <= '0;
      r_addr_err    <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_load_fire) begin
            r_load_ptr <= r_load_ptr + PTR_ONE;
          end
          if (bus.load_done) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!w_pc_in_range) begin
            r_addr_err <= 1'b1;
            r_state    <= S_HALT;
          end else if (w_is_halt) begin
            r_state <= S_HALT;
          end else if (r_fetch_count != 16'hFFFF) begin
            r_fetch_count <= r_fetch_count + 16'd1;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

  // The read path is combinational, so a stall shows up in the same cycle as the offending PC.
  assign bus.load_ready  = w_load_ready;
  assign bus.instr_valid = w_issue;
  assign bus.instruction = w_issue ? w_rd_word : '0;
  assign bus.cpu_stall   = !w_issue;
  assign bus.addr_err    = r_addr_err;
  assign bus.fetch_count = r_fetch_count;

endmodule
